// File: rtl/ag32gbd_ram_arb.sv
// Purpose: shares the cartridge SRAM port between the cart mapper path and NUM_CH internal byte-write channels.
// Latency: cart path is combinational in PASS; an internal write completes 1+SETUP+PULSE+HOLD cycles after its request is sampled.
// Backpressure: channel requests are levels held until ch_done; cart_req is stalled (cart_stall) until an in-flight write finishes.
module ag32gbd_ram_arb #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 17,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                     sys_clock,
    input  logic                     resetn,
    input  logic                     cart_req,
    input  logic [ADDR_W-1:0]        cart_addr,
    input  logic                     cart_nCS,
    input  logic                     cart_nWE,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*8-1:0]      ch_data,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     ram_nCS,
    output logic                     ram_nWE,
    output logic [7:0]               ram_dout,
    output logic                     ram_doe,
    output logic                     busy,
    output logic                     cart_stall
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PASS  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_cnt_last;
    logic [PTR_W-1:0]    r_rr_ptr;
    logic [PTR_W-1:0]    w_rr_next;
    logic [PTR_W-1:0]    r_gnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_data;
    logic [2*NUM_CH-1:0] w_req_dbl;
    logic [NUM_CH-1:0]   w_req_rot;
    logic                w_gnt_vld;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [PTR_W:0]      w_idx_sum;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [7:0]          w_sel_data;
    logic                w_grant;
    logic                w_done_pulse;

    // Rotate requests so bit 0 is the channel at rr_ptr; the first set bit is then the winner.
    assign w_req_dbl = {ch_req, ch_req} >> r_rr_ptr;
    assign w_req_rot = w_req_dbl[NUM_CH-1:0];

    // Round-robin pick: lowest offset from rr_ptr, mapped back to an absolute channel index.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_idx_sum = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_gnt_vld && w_req_rot[k]) begin
                w_gnt_vld = 1'b1;
                w_idx_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
                if (w_idx_sum >= (PTR_W+1)'(NUM_CH)) begin
                    w_idx_sum = w_idx_sum - (PTR_W+1)'(NUM_CH);
                end
                w_gnt_idx = w_idx_sum[PTR_W-1:0];
            end
        end
    end

    // Mux the winning channel's address and data toward the holding registers.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt_idx == PTR_W'(i)) begin
                w_sel_addr = ch_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = ch_data[i*8 +: 8];
            end
        end
    end

    // Flag the final cycle of the current timed phase.
    always_comb begin
        w_cnt_last = 1'b0;
        case (r_state)
            S_SETUP: w_cnt_last = (r_cnt == CNT_W'(SETUP_CYC - 1));
            S_PULSE: w_cnt_last = (r_cnt == CNT_W'(PULSE_CYC - 1));
            S_HOLD:  w_cnt_last = (r_cnt == CNT_W'(HOLD_CYC - 1));
            default: w_cnt_last = 1'b0;
        endcase
    end

    assign w_grant      = (r_state == S_IDLE) && !cart_req && w_gnt_vld;
    assign w_done_pulse = (r_state == S_HOLD) && w_cnt_last;
    assign w_rr_next    = (r_gnt == PTR_W'(NUM_CH - 1)) ? '0 : r_gnt + PTR_W'(1);

    // Next-state logic: cart wins in IDLE; a started write always runs to the end of HOLD.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cart_req) begin
                    w_next_state = S_PASS;
                end else if (w_gnt_vld) begin
                    w_next_state = S_SETUP;
                end
            end
            S_PASS:  if (!cart_req)  w_next_state = S_IDLE;
            S_SETUP: if (w_cnt_last) w_next_state = S_PULSE;
            S_PULSE: if (w_cnt_last) w_next_state = S_HOLD;
            S_HOLD:  if (w_cnt_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register and phase counter; the counter restarts from zero on every state entry.
    always_ff @(posedge sys_clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state != r_state || w_next_state == S_IDLE || w_next_state == S_PASS) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Capture the granted write so later channel input changes cannot disturb it; advance rr_ptr on completion.
    always_ff @(posedge sys_clock) begin
        if (!resetn) begin
            r_gnt    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_grant) begin
                r_gnt  <= w_gnt_idx;
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
            end
            if (w_done_pulse) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    // SRAM port drive: cart passthrough in PASS, latched write during SETUP/PULSE/HOLD, inactive otherwise.
    always_comb begin
        ram_addr = '0;
        ram_nCS  = 1'b1;
        ram_nWE  = 1'b1;
        ram_dout = '0;
        ram_doe  = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_PASS: begin
                ram_addr = cart_addr;
                ram_nCS  = cart_nCS;
                ram_nWE  = cart_nWE;
            end
            S_SETUP, S_PULSE, S_HOLD: begin
                ram_addr = r_addr;
                ram_nCS  = 1'b0;
                ram_nWE  = (r_state != S_PULSE);
                ram_dout = r_data;
                ram_doe  = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    assign cart_stall = cart_req && (r_state != S_PASS);

    // Completion pulse to the granted channel on the last HOLD cycle.
    always_comb begin
        ch_done = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_done[i] = w_done_pulse && (r_gnt == PTR_W'(i));
        end
    end

endmodule

// File: tb/tb_ag32gbd_ram_arb.sv
// Bench for ag32gbd_ram_arb: default instance under directed + random stimulus against a timestamp model,
// plus a 4-channel instance with stretched timing. Completed writes are scoreboarded through queues.
module tb_ag32gbd_ram_arb;

    localparam int AW = 17;
    localparam int N  = 2;
    localparam int S  = 1;
    localparam int P  = 2;
    localparam int H  = 1;
    localparam int T  = S + P + H;
    localparam int SN = 4;
    localparam int SP = 3;
    localparam int ST = 2 + 3 + 2;

    typedef struct {
        int          ch;
        logic [AW-1:0] addr;
        logic [7:0]  data;
        int          g;
    } wr_t;

    typedef struct {
        int          ch;
        int          dc;
        logic [AW-1:0] addr;
        logic [7:0]  data;
    } sw_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic              cart_req;
    logic [AW-1:0]     cart_addr;
    logic              cart_nCS;
    logic              cart_nWE;
    logic [N-1:0]      ch_req;
    logic [N*AW-1:0]   ch_addr;
    logic [N*8-1:0]    ch_data;
    logic [N-1:0]      ch_done;
    logic [AW-1:0]     ram_addr;
    logic              ram_nCS;
    logic              ram_nWE;
    logic [7:0]        ram_dout;
    logic              ram_doe;
    logic              busy;
    logic              cart_stall;

    logic              sw_cart_req;
    logic [AW-1:0]     sw_cart_addr;
    logic              sw_cart_nCS;
    logic              sw_cart_nWE;
    logic [SN-1:0]     sw_req;
    logic [SN*AW-1:0]  sw_addr;
    logic [SN*8-1:0]   sw_data;
    logic [SN-1:0]     sw_done;
    logic [AW-1:0]     sw_ram_addr;
    logic              sw_nCS;
    logic              sw_nWE;
    logic [7:0]        sw_dout;
    logic              sw_doe;
    logic              sw_busy;
    logic              sw_stall;

    ag32gbd_ram_arb u_dut (
        .sys_clock (clk),       .resetn    (resetn),
        .cart_req  (cart_req),  .cart_addr (cart_addr),
        .cart_nCS  (cart_nCS),  .cart_nWE  (cart_nWE),
        .ch_req    (ch_req),    .ch_addr   (ch_addr),
        .ch_data   (ch_data),   .ch_done   (ch_done),
        .ram_addr  (ram_addr),  .ram_nCS   (ram_nCS),
        .ram_nWE   (ram_nWE),   .ram_dout  (ram_dout),
        .ram_doe   (ram_doe),   .busy      (busy),
        .cart_stall(cart_stall)
    );

    ag32gbd_ram_arb #(.NUM_CH(4), .ADDR_W(AW), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_sw (
        .sys_clock (clk),          .resetn    (resetn),
        .cart_req  (sw_cart_req),  .cart_addr (sw_cart_addr),
        .cart_nCS  (sw_cart_nCS),  .cart_nWE  (sw_cart_nWE),
        .ch_req    (sw_req),       .ch_addr   (sw_addr),
        .ch_data   (sw_data),      .ch_done   (sw_done),
        .ram_addr  (sw_ram_addr),  .ram_nCS   (sw_nCS),
        .ram_nWE   (sw_nWE),       .ram_dout  (sw_dout),
        .ram_doe   (sw_doe),       .busy      (sw_busy),
        .cart_stall(sw_stall)
    );

    int  checks = 0;
    int  errors = 0;
    int  tmo    = 0;
    bit  hold   = 1'b0;
    bit  fin_req = 1'b0;
    int  cyc    = 0;

    // Reference model of the default instance: timestamps of arbitration points, no state encoding.
    wr_t q[$];
    sw_t sq[$];
    int  m_free = 0;
    bit  m_pass = 1'b0;
    int  m_rr   = 0;
    bit  m_act  = 1'b0;
    int  m_rst  = -1;
    wr_t m_cur;

    always @(posedge clk) begin
        bit found;
        cyc = cyc + 1;
        if (!resetn) begin
            q.delete();
            m_pass = 1'b0;
            m_rr   = 0;
            m_act  = 1'b0;
            m_free = cyc + 1;
            m_rst  = cyc;
        end else if (m_pass) begin
            if (!cart_req) begin
                m_pass = 1'b0;
                m_free = cyc + 1;
            end
        end else if (cyc >= m_free) begin
            if (cart_req) begin
                m_pass = 1'b1;
            end else begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_rr + k) % N;
                    if (!found && ch_req[j]) begin
                        found      = 1'b1;
                        m_cur.ch   = j;
                        m_cur.addr = ch_addr[j*AW +: AW];
                        m_cur.data = ch_data[j*8 +: 8];
                        m_cur.g    = cyc;
                        m_act      = 1'b1;
                        m_rr       = (j + 1) % N;
                        m_free     = cyc + T + 1;
                        q.push_back(m_cur);
                    end
                end
            end
        end
    end

    // Monitor: all comparisons, sampled on the falling edge.
    int nwe_len = 0, ncs_len = 0, sw_nwe_len = 0, sw_ncs_len = 0;

    always @(negedge clk) begin
        bit            won, bad;
        logic [AW-1:0] ea;
        logic          enc, enw, edoe, ebusy, estall, chk_addr;
        logic [7:0]    ed;
        logic [N-1:0]  edone, oh;
        logic [SN-1:0] soh;
        wr_t           w;
        sw_t           sv;

        won      = m_act && (cyc >= m_cur.g) && (cyc <= m_cur.g + T - 1);
        ea       = '0;
        ed       = '0;
        enc      = 1'b1;
        enw      = 1'b1;
        edoe     = 1'b0;
        ebusy    = 1'b0;
        chk_addr = 1'b0;
        edone    = '0;
        estall   = cart_req && !m_pass;
        if (m_pass) begin
            ea = cart_addr; enc = cart_nCS; enw = cart_nWE; chk_addr = 1'b1;
        end else if (won) begin
            ea = m_cur.addr; ed = m_cur.data; enc = 1'b0; edoe = 1'b1; ebusy = 1'b1; chk_addr = 1'b1;
            enw = !((cyc >= m_cur.g + S) && (cyc <= m_cur.g + S + P - 1));
            if (cyc == m_cur.g + T - 1) edone[m_cur.ch] = 1'b1;
        end
        bad = (chk_addr && ram_addr !== ea) || (won && ram_dout !== ed) ||
              ram_nCS !== enc || ram_nWE !== enw || ram_doe !== edoe ||
              busy !== ebusy || cart_stall !== estall || ch_done !== edone;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bus cyc=%0d got addr=%h nCS=%b nWE=%b doe=%b dout=%h busy=%b stall=%b done=%b want addr=%h nCS=%b nWE=%b doe=%b dout=%h busy=%b stall=%b done=%b",
                     cyc, ram_addr, ram_nCS, ram_nWE, ram_doe, ram_dout, busy, cart_stall, ch_done,
                     ea, enc, enw, edoe, ed, ebusy, estall, edone);
        end

        if (cyc == m_rst) begin
            checks++;
            if (ram_addr !== '0 || ram_dout !== '0 || ch_done !== '0 || sw_ram_addr !== '0 ||
                sw_nCS !== 1'b1 || sw_nWE !== 1'b1 || sw_doe !== 1'b0 || sw_busy !== 1'b0 || sw_done !== '0) begin
                errors++;
                $display("FAIL reset cyc=%0d got addr=%h dout=%h done=%b sw_addr=%h sw_nCS=%b sw_nWE=%b sw_doe=%b sw_busy=%b sw_done=%b want zeros/inactive",
                         cyc, ram_addr, ram_dout, ch_done, sw_ram_addr, sw_nCS, sw_nWE, sw_doe, sw_busy, sw_done);
            end
        end

        if (ram_doe && !ram_nWE) nwe_len++;
        if (ram_doe && !ram_nCS) ncs_len++;
        if (ch_done != '0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d got done=%b want no completion", cyc, ch_done);
            end else begin
                w  = q.pop_front();
                oh = '0;
                oh[w.ch] = 1'b1;
                if (ch_done !== oh || cyc != w.g + T - 1 || nwe_len != P || ncs_len != T) begin
                    errors++;
                    $display("FAIL done cyc=%0d got done=%b nwe_len=%0d ncs_len=%0d want done=%b cyc=%0d nwe_len=%0d ncs_len=%0d",
                             cyc, ch_done, nwe_len, ncs_len, oh, w.g + T - 1, P, T);
                end
            end
            nwe_len = 0;
            ncs_len = 0;
        end

        if (sw_doe && !sw_nWE) sw_nwe_len++;
        if (sw_doe && !sw_nCS) sw_ncs_len++;
        if (sw_done != '0) begin
            checks++;
            if (sq.size() == 0) begin
                errors++;
                $display("FAIL sw_done_unexpected cyc=%0d got done=%b want no completion", cyc, sw_done);
            end else begin
                sv  = sq.pop_front();
                soh = '0;
                soh[sv.ch] = 1'b1;
                if (sw_done !== soh || cyc != sv.dc || sw_nwe_len != SP || sw_ncs_len != ST ||
                    sw_ram_addr !== sv.addr || sw_dout !== sv.data) begin
                    errors++;
                    $display("FAIL sw_done cyc=%0d got done=%b nwe_len=%0d ncs_len=%0d addr=%h dout=%h want done=%b cyc=%0d nwe_len=%0d ncs_len=%0d addr=%h dout=%h",
                             cyc, sw_done, sw_nwe_len, sw_ncs_len, sw_ram_addr, sw_dout,
                             soh, sv.dc, SP, ST, sv.addr, sv.data);
                end
            end
            sw_nwe_len = 0;
            sw_ncs_len = 0;
        end

        if (!resetn) begin
            nwe_len = 0; ncs_len = 0; sw_nwe_len = 0; sw_ncs_len = 0;
        end

        if (fin_req) begin
            checks++;
            if (tmo != 0 || q.size() != 0 || sq.size() != 0) begin
                errors++;
                $display("FAIL final got timeouts=%0d pending=%0d sw_pending=%0d want 0/0/0", tmo, q.size(), sq.size());
            end
        end
    end

    // One clock; inputs change 1 time unit after the rising edge. Completed channels drop their request.
    task automatic step();
        @(posedge clk);
        #1;
        if (!hold) ch_req = ch_req & ~ch_done;
        sw_req = sw_req & ~sw_done;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 120 && !ok; i++) begin
            step();
            if (!busy && ch_req == '0 && !sw_busy && sw_req == '0) ok = 1'b1;
        end
        if (!ok) begin
            tmo++;
            $display("FAIL wait_idle timeout at cyc=%0d", cyc);
        end
    endtask

    task automatic wait_pulse();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            if (ram_doe && !ram_nWE) ok = 1'b1;
        end
        if (!ok) begin
            tmo++;
            $display("FAIL wait_pulse timeout at cyc=%0d", cyc);
        end
    endtask

    task automatic push_sw(input int ch, input int dc, input logic [AW-1:0] ad, input logic [7:0] d);
        sw_t e;
        e.ch = ch; e.dc = dc; e.addr = ad; e.data = d;
        sq.push_back(e);
    endtask

    initial begin
        int a, nd;
        resetn = 1'b0;
        cart_req = 1'b0; cart_addr = '0; cart_nCS = 1'b1; cart_nWE = 1'b1;
        ch_req = '0; ch_addr = '0; ch_data = '0;
        sw_cart_req = 1'b0; sw_cart_addr = '0; sw_cart_nCS = 1'b1; sw_cart_nWE = 1'b1;
        sw_req = '0; sw_addr = '0; sw_data = '0;
        repeat (3) step();
        resetn = 1'b1;
        step();

        // Stretched-timing instance: one write on ch0 moves rr_ptr to 1, then 0/2/3 together serve 2,3,0.
        sw_addr = {17'h13333, 17'h12222, 17'h11111, 17'h10000};
        sw_data = 32'h44332211;
        sw_req  = 4'b0001;
        a = cyc + 1;
        push_sw(0, a + ST - 1, 17'h10000, 8'h11);
        wait_idle();
        step(); step();
        sw_req = 4'b1101;
        a = cyc + 1;
        push_sw(2, a + ST - 1, 17'h12222, 8'h33);
        push_sw(3, a + (ST + 1) + ST - 1, 17'h13333, 8'h44);
        push_sw(0, a + 2 * (ST + 1) + ST - 1, 17'h10000, 8'h11);
        wait_idle();

        // Single write on channel 0.
        ch_addr[0 +: AW] = 17'h00123;
        ch_data[0 +: 8]  = 8'hA5;
        ch_req = 2'b01;
        wait_idle();

        // Both channels held: alternating service.
        hold = 1'b1;
        ch_addr = {17'h0BEEF, 17'h00456};
        ch_data = {8'h5A, 8'h3C};
        ch_req = 2'b11;
        nd = 0;
        for (int i = 0; i < 80 && nd < 4; i++) begin
            step();
            if (ch_done != '0) nd++;
        end
        if (nd < 4) begin
            tmo++;
            $display("FAIL rr_wait timeout got %0d completions want 4", nd);
        end
        ch_req = '0;
        hold = 1'b0;
        wait_idle();

        // Cart and channel 1 arrive together: cart first, then the write.
        cart_addr = 17'h1E000; cart_nCS = 1'b0; cart_nWE = 1'b0;
        cart_req = 1'b1;
        ch_req = 2'b10;
        repeat (4) step();
        cart_req = 1'b0; cart_nCS = 1'b1; cart_nWE = 1'b1;
        wait_idle();

        // Cart arrives during nWE low: the write finishes, cart stalls until PASS.
        ch_req = 2'b01;
        wait_pulse();
        cart_req = 1'b1;
        cart_addr = 17'h00777;
        repeat (8) step();
        cart_req = 1'b0;
        wait_idle();

        // Reset during PULSE aborts the write; channel 1 then wins from rr_ptr=0.
        ch_req = 2'b01;
        wait_pulse();
        resetn = 1'b0;
        ch_req = 2'b10;
        step();
        resetn = 1'b1;
        wait_idle();

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            step();
            if (!resetn) resetn = 1'b1;
            else if ($urandom_range(0, 599) == 0) resetn = 1'b0;
            if (!cart_req) cart_req = ($urandom_range(0, 24) == 0);
            else           cart_req = ($urandom_range(0, 5) != 0);
            cart_addr = AW'($urandom);
            cart_nCS  = 1'($urandom);
            cart_nWE  = 1'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!ch_req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        ch_req[i] = 1'b1;
                        ch_addr[i*AW +: AW] = AW'($urandom);
                        ch_data[i*8 +: 8]   = 8'($urandom);
                    end
                end else begin
                    if ($urandom_range(0, 49) == 0) ch_req[i] = 1'b0;
                    if ($urandom_range(0, 3) == 0) ch_data[i*8 +: 8] = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) ch_addr[i*AW +: AW] = AW'($urandom);
                end
            end
        end
        resetn = 1'b1;
        cart_req = 1'b0;
        ch_req = '0;
        wait_idle();
        step();

        fin_req = 1'b1;
        step();
        fin_req = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
